// File: rtl/rx_packet_marker.sv
// rx_packet_marker: per-channel AXI-stream stage that stamps a free-running
// packet sequence marker into CHDR data packets of a programmable type.
// Replace mode overwrites the final sample; append mode adds a marker beat
// after it and grows the header length field by one sample.
// Optional macro RX_PACKET_MARKER_TIMESTAMP_EN: with DATA_WIDTH >= 64 the
// appended marker beat carries {marker, low timestamp bits}.
module rx_packet_marker #(
  parameter int NUM_CHANNELS = 1,
  parameter int DATA_WIDTH = 32,
  parameter int MARKER_WIDTH = 32,
  parameter logic [7:0] SR_MARKER_CTRL = 8'd160,
  parameter logic [7:0] SR_MARKER_CLR = 8'd161
) (
  input  logic                               ce_clk,
  input  logic                               ce_rst_n,
  input  logic [NUM_CHANNELS-1:0]            set_stb,
  input  logic [NUM_CHANNELS*8-1:0]          set_addr,
  input  logic [NUM_CHANNELS*32-1:0]         set_data,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_CHANNELS*128-1:0]        s_axis_tuser,
  input  logic [NUM_CHANNELS-1:0]            s_axis_tlast,
  input  logic [NUM_CHANNELS-1:0]            s_axis_tvalid,
  output logic [NUM_CHANNELS-1:0]            s_axis_tready,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [NUM_CHANNELS*128-1:0]        m_axis_tuser,
  output logic [NUM_CHANNELS-1:0]            m_axis_tlast,
  output logic [NUM_CHANNELS-1:0]            m_axis_tvalid,
  input  logic [NUM_CHANNELS-1:0]            m_axis_tready
);

  localparam int unsigned TS_BITS = DATA_WIDTH - MARKER_WIDTH;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    typedef enum logic {S_PASS, S_APPEND} state_t;

    state_t                  state;
    logic [7:0]              saddr;
    logic [31:0]             sdata;
    logic                    ctrl_wr, clr_wr;
    logic                    ctrl_en, ctrl_mode, ctrl_any;
    logic [3:0]              ctrl_type;
    logic                    sh_en, sh_mode, sh_any;
    logic [3:0]              sh_type;
    logic                    sop;
    logic                    cur_en, cur_mode, cur_any;
    logic [3:0]              cur_type;
    logic                    matched, in_fire, mark_fire;
    logic [MARKER_WIDTH-1:0] cnt, hold_cnt;
    logic [127:0]            hold_user;
    logic [DATA_WIDTH-1:0]   in_data, o_data, rep_marker, app_marker;
    logic [127:0]            in_user, user_adj, o_user;
    logic                    in_last, in_valid, out_ready;
    logic                    o_last, o_valid, o_ready;
    logic                    unused_sdata;

    assign saddr     = set_addr[i*8 +: 8];
    assign sdata     = set_data[i*32 +: 32];
    assign in_data   = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign in_user   = s_axis_tuser[i*128 +: 128];
    assign in_last   = s_axis_tlast[i];
    assign in_valid  = s_axis_tvalid[i];
    assign out_ready = m_axis_tready[i];

    assign ctrl_wr = set_stb[i] && (saddr == SR_MARKER_CTRL);
    assign clr_wr  = set_stb[i] && (saddr == SR_MARKER_CLR) && sdata[0];
    assign unused_sdata = ^{sdata[31:9], sdata[3:2]};

    // The first beat of a packet sees the live control register; later beats
    // see the copy latched on that first beat.
    assign cur_en   = sop ? ctrl_en   : sh_en;
    assign cur_mode = sop ? ctrl_mode : sh_mode;
    assign cur_any  = sop ? ctrl_any  : sh_any;
    assign cur_type = sop ? ctrl_type : sh_type;

    assign matched   = cur_en && (cur_any || (in_user[127:124] == cur_type));
    assign in_fire   = (state == S_PASS) && in_valid && out_ready;
    assign mark_fire = in_fire && matched && in_last;

    assign rep_marker = DATA_WIDTH'(cnt);

    // Header with the length field grown by one sample for append mode
    always_comb begin
      user_adj = in_user;
      user_adj[111:96] = in_user[111:96] + 16'(DATA_WIDTH / 8);
    end

`ifdef RX_PACKET_MARKER_TIMESTAMP_EN
    if (DATA_WIDTH >= 64) begin : g_ts
      logic [DATA_WIDTH-1:0] ts_ext;
      assign ts_ext = DATA_WIDTH'(hold_user[63:0]);
      // Marker in the top bits, packet timestamp low bits underneath
      always_comb begin
        app_marker = '0;
        app_marker[DATA_WIDTH-1 -: MARKER_WIDTH] = hold_cnt;
        for (int unsigned b = 0; b < TS_BITS; b++) app_marker[b] = ts_ext[b];
      end
    end else begin : g_nots
      assign app_marker = DATA_WIDTH'(hold_cnt);
    end
`else
    assign app_marker = DATA_WIDTH'(hold_cnt);
`endif

    // Output mux: zero-latency pass-through in PASS, held marker beat in APPEND
    always_comb begin
      if (state == S_APPEND) begin
        o_valid = 1'b1;
        o_data  = app_marker;
        o_last  = 1'b1;
        o_user  = hold_user;
        o_ready = 1'b0;
      end else begin
        o_valid = in_valid;
        o_data  = (matched && in_last && !cur_mode) ? rep_marker : in_data;
        o_last  = in_last && !(matched && cur_mode);
        o_user  = (matched && cur_mode) ? user_adj : in_user;
        o_ready = out_ready;
      end
    end

    assign m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] = o_data;
    assign m_axis_tuser[i*128 +: 128]               = o_user;
    assign m_axis_tlast[i]                          = o_last;
    assign m_axis_tvalid[i]                         = o_valid;
    assign s_axis_tready[i]                         = o_ready;

    // Control/shadow registers, SOP tracking, marker counter and the FSM
    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
      if (!ce_rst_n) begin
        state     <= S_PASS;
        ctrl_en   <= 1'b0;
        ctrl_mode <= 1'b0;
        ctrl_type <= 4'b0010;
        ctrl_any  <= 1'b0;
        sh_en     <= 1'b0;
        sh_mode   <= 1'b0;
        sh_type   <= 4'b0010;
        sh_any    <= 1'b0;
        sop       <= 1'b1;
        cnt       <= '0;
        hold_cnt  <= '0;
        hold_user <= '0;
      end else begin
        if (ctrl_wr) begin
          ctrl_en   <= sdata[0];
          ctrl_mode <= sdata[1];
          ctrl_type <= sdata[7:4];
          ctrl_any  <= sdata[8];
        end
        if (in_fire) begin
          if (sop) begin
            sh_en   <= ctrl_en;
            sh_mode <= ctrl_mode;
            sh_type <= ctrl_type;
            sh_any  <= ctrl_any;
          end
          sop <= in_last;
        end
        if (clr_wr) cnt <= '0;
        else if (mark_fire) cnt <= cnt + MARKER_WIDTH'(1);
        case (state)
          S_PASS: begin
            // Pre-increment count is captured so a same-cycle clear cannot
            // disturb the marker still to be emitted.
            if (mark_fire && cur_mode) begin
              hold_user <= user_adj;
              hold_cnt  <= cnt;
              state     <= S_APPEND;
            end
          end
          S_APPEND: begin
            if (out_ready) begin
              state <= S_PASS;
              sop   <= 1'b1;
            end
          end
          default: state <= S_PASS;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_packet_marker.sv
// Testbench for rx_packet_marker: directed vector table plus hand-written
// sequences for backpressure, counter wrap, clear/control timing and reset.
module tb_rx_packet_marker;

  localparam logic [7:0] CTRL = 8'd160;
  localparam logic [7:0] CLR  = 8'd161;

  logic         ce_clk = 1'b0;
  logic         ce_rst_n;
  logic [0:0]   set_stb;
  logic [7:0]   set_addr;
  logic [31:0]  set_data;
  logic [31:0]  s_tdata;
  logic [127:0] s_tuser;
  logic         s_tlast, s_tvalid, s_tready, m_tready;
  logic [31:0]  m_tdata;
  logic [127:0] m_tuser;
  logic         m_tlast, m_tvalid;
  logic [31:0]  m_tdata4;
  logic [127:0] unused_user4;
  logic         unused_last4, unused_valid4, unused_ready4;

  int checks = 0;
  int failures = 0;

  always #5 ce_clk = ~ce_clk;

  rx_packet_marker #(.NUM_CHANNELS(1), .DATA_WIDTH(32), .MARKER_WIDTH(32)) dut (
    .ce_clk(ce_clk), .ce_rst_n(ce_rst_n),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready));

  rx_packet_marker #(.NUM_CHANNELS(1), .DATA_WIDTH(32), .MARKER_WIDTH(4)) dut4 (
    .ce_clk(ce_clk), .ce_rst_n(ce_rst_n),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(unused_ready4),
    .m_axis_tdata(m_tdata4), .m_axis_tuser(unused_user4), .m_axis_tlast(unused_last4),
    .m_axis_tvalid(unused_valid4), .m_axis_tready(m_tready));

  typedef struct {
    logic        stb;
    logic [7:0]  addr;
    logic [31:0] sdat;
    logic        v, l;
    logic [31:0] d;
    logic [3:0]  typ;
    logic [15:0] len;
    logic        mr;
    logic        ev, el;
    logic [31:0] ed;
    logic [15:0] elen;
    logic        esr;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic [15:0] len;
  } exp_t;

  vec_t tbl[$];
  exp_t expq[$];

  function automatic logic [127:0] mk_user(input logic [3:0] typ, input logic [15:0] len);
    return {typ, 12'h0A5, len, 32'h1234_5678, 64'h0000_0000_CAFE_0001};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic stb, input logic [7:0] addr, input logic [31:0] sdat,
                     input logic v, input logic l, input logic [31:0] d, input logic [3:0] typ,
                     input logic [15:0] len, input logic mr, input logic ev, input logic el,
                     input logic [31:0] ed, input logic [15:0] elen, input logic esr);
    vec_t r;
    r.stb = stb; r.addr = addr; r.sdat = sdat; r.v = v; r.l = l; r.d = d; r.typ = typ;
    r.len = len; r.mr = mr; r.ev = ev; r.el = el; r.ed = ed; r.elen = elen; r.esr = esr;
    tbl.push_back(r);
  endtask

  task automatic drive(input logic v, input logic l, input logic [31:0] d,
                       input logic [3:0] typ, input logic [15:0] len, input logic mr);
    s_tvalid = v; s_tlast = l; s_tdata = d; s_tuser = mk_user(typ, len); m_tready = mr;
  endtask

  task automatic tick();
    @(posedge ce_clk);
    @(negedge ce_clk);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    set_stb = 1'b1; set_addr = addr; set_data = data;
    tick();
    set_stb = 1'b0;
  endtask

  initial begin
    int pkt, beat, plen, markers, cyc;
    logic presenting, in_fire, out_fire;
    exp_t e;

    ce_rst_n = 1'b0;
    set_stb = 1'b0; set_addr = '0; set_data = '0;
    drive(0, 0, 32'h0, 4'd2, 16'd16, 1);
    @(negedge ce_clk);
    #1;
    chk("reset_tvalid", m_tvalid, 0);
    chk("reset_tready", s_tready, 1);
    ce_rst_n = 1'b1;
    tick();

    // Replace mode, type 2, three 4-beat packets
    add(1, CTRL, 32'h21, 0, 0, 0, 2, 16, 1, 0, 0, 0, 16, 1);
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 4; k++)
        add(0, 0, 0, 1, k == 3, 32'h100 + p * 16 + k, 2, 16, 1,
            1, k == 3, (k == 3) ? p : 32'h100 + p * 16 + k, 16, 1);
    // Clear, then append mode: 4 beats of length 16 -> 5 beats, length 20
    add(1, CLR, 32'h1, 0, 0, 0, 2, 16, 1, 0, 0, 0, 16, 1);
    add(1, CTRL, 32'h23, 0, 0, 0, 2, 16, 1, 0, 0, 0, 16, 1);
    for (int k = 0; k < 4; k++)
      add(0, 0, 0, 1, k == 3, 32'h200 + k, 2, 16, 1, 1, 0, 32'h200 + k, 20, 1);
    add(0, 0, 0, 1, 0, 32'h300, 2, 16, 1, 1, 1, 32'h0, 20, 0);
    add(0, 0, 0, 1, 0, 32'h300, 2, 16, 1, 1, 0, 32'h300, 20, 1);
    add(0, 0, 0, 1, 1, 32'h301, 2, 16, 1, 1, 0, 32'h301, 20, 1);
    add(0, 0, 0, 0, 0, 32'h0, 2, 16, 1, 1, 1, 32'h1, 20, 0);
    add(0, 0, 0, 0, 0, 32'h0, 2, 16, 1, 0, 0, 0, 16, 1);
    // Type filter: type 0 passes untouched, then match_any marks it
    add(1, CTRL, 32'h21, 0, 0, 0, 2, 16, 1, 0, 0, 0, 16, 1);
    add(0, 0, 0, 1, 0, 32'h400, 0, 16, 1, 1, 0, 32'h400, 16, 1);
    add(0, 0, 0, 1, 1, 32'h401, 0, 16, 1, 1, 1, 32'h401, 16, 1);
    add(1, CTRL, 32'h121, 0, 0, 0, 0, 16, 1, 0, 0, 0, 16, 1);
    add(0, 0, 0, 1, 0, 32'h410, 0, 16, 1, 1, 0, 32'h410, 16, 1);
    add(0, 0, 0, 1, 1, 32'h411, 0, 16, 1, 1, 1, 32'h2, 16, 1);
    // Single-beat append packet
    add(1, CTRL, 32'h23, 0, 0, 0, 2, 4, 1, 0, 0, 0, 4, 1);
    add(0, 0, 0, 1, 1, 32'h500, 2, 4, 1, 1, 0, 32'h500, 8, 1);
    add(0, 0, 0, 0, 0, 32'h0, 2, 4, 1, 1, 1, 32'h3, 8, 0);
    add(0, 0, 0, 0, 0, 32'h0, 2, 4, 1, 0, 0, 0, 4, 1);
    // Single-beat replace packet under backpressure: counter waits for transfer
    add(1, CTRL, 32'h21, 0, 0, 0, 2, 16, 1, 0, 0, 0, 16, 1);
    add(0, 0, 0, 1, 1, 32'h600, 2, 16, 0, 1, 1, 32'h4, 16, 0);
    add(0, 0, 0, 1, 1, 32'h600, 2, 16, 1, 1, 1, 32'h4, 16, 1);

    foreach (tbl[i]) begin
      set_stb = tbl[i].stb; set_addr = tbl[i].addr; set_data = tbl[i].sdat;
      drive(tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].typ, tbl[i].len, tbl[i].mr);
      #1;
      chk($sformatf("vec%0d_valid", i), m_tvalid, tbl[i].ev);
      chk($sformatf("vec%0d_sready", i), s_tready, tbl[i].esr);
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_last", i), m_tlast, tbl[i].el);
        chk($sformatf("vec%0d_data", i), m_tdata, tbl[i].ed);
        chk($sformatf("vec%0d_user", i), m_tuser, mk_user(tbl[i].typ, tbl[i].elen));
      end
      tick();
    end
    set_stb = 1'b0;
    drive(0, 0, 0, 2, 16, 1);

    // Append mode with random valid/ready: markers 0..99 in order, none lost
    wr(CLR, 32'h1);
    wr(CTRL, 32'h23);
    pkt = 0; beat = 0; plen = 1; markers = 0; cyc = 0; presenting = 1'b0;
    while (markers < 100 && cyc < 6000) begin
      if (!presenting && pkt < 100 && ($urandom % 4 != 0)) begin
        presenting = 1'b1;
        if (beat == 0) plen = $urandom_range(1, 4);
      end
      drive(presenting, beat == plen - 1, 32'hB000_0000 | (pkt << 8) | beat, 2,
            16'(plen * 4), ($urandom % 3 != 0));
      #1;
      in_fire  = s_tvalid && s_tready;
      out_fire = m_tvalid && m_tready;
      if (in_fire) begin
        expq.push_back('{d: s_tdata, l: 1'b0, len: 16'(plen * 4 + 4)});
        if (s_tlast) expq.push_back('{d: 32'(pkt), l: 1'b1, len: 16'(plen * 4 + 4)});
      end
      if (out_fire) begin
        if (expq.size() == 0) begin
          chk("bp_unexpected_beat", {m_tdata, m_tlast}, '0);
        end else begin
          e = expq.pop_front();
          chk("bp_beat", {m_tdata, m_tlast, m_tuser[111:96]}, {e.d, e.l, e.len});
          if (e.l) markers++;
        end
      end
      tick();
      cyc++;
      if (in_fire) begin
        if (beat == plen - 1) begin
          beat = 0; pkt++; presenting = 1'b0;
        end else begin
          beat++;
        end
      end
    end
    chk("bp_markers", 128'(markers), 128'd100);
    chk("bp_queue_empty", 128'(expq.size()), 128'd0);
    drive(0, 0, 0, 2, 16, 1);

    // 4-bit marker wraps 15 -> 0; 32-bit marker keeps counting
    wr(CLR, 32'h1);
    wr(CTRL, 32'h21);
    for (int k = 0; k < 17; k++) begin
      drive(1, 1, 32'h700 + k, 2, 16, 1);
      #1;
      chk($sformatf("wrap4_%0d", k), m_tdata4, 32'(k % 16));
      if (k == 16) chk("wrap32_16", m_tdata, 32'd16);
      tick();
    end

    // Clear in the same cycle as a marked transfer: clear wins
    set_stb = 1'b1; set_addr = CLR; set_data = 32'h1;
    drive(1, 1, 32'h800, 2, 16, 1);
    #1;
    chk("clr_same_marker", m_tdata, 32'd17);
    tick();
    set_stb = 1'b0;
    drive(1, 1, 32'h801, 2, 16, 1);
    #1;
    chk("clr_after_marker", m_tdata, 32'd0);
    tick();

    // Control write during a packet only applies to the next packet
    set_stb = 1'b1; set_addr = CTRL; set_data = 32'h0;
    drive(1, 0, 32'h900, 2, 16, 1);
    #1;
    chk("mid_ctrl_first", m_tdata, 32'h900);
    tick();
    set_stb = 1'b0;
    drive(1, 1, 32'h901, 2, 16, 1);
    #1;
    chk("mid_ctrl_still_marked", m_tdata, 32'd1);
    tick();
    drive(1, 1, 32'h902, 2, 16, 1);
    #1;
    chk("mid_ctrl_next_off", m_tdata, 32'h902);
    tick();

    // Reset while a marker beat is pending in APPEND
    wr(CTRL, 32'h23);
    drive(1, 1, 32'hA00, 2, 16, 1);
    #1;
    chk("rst_pre_last", m_tlast, 0);
    tick();
    drive(0, 0, 0, 2, 16, 0);
    #1;
    chk("rst_pending_valid", m_tvalid, 1);
    chk("rst_pending_marker", m_tdata, 32'd2);
    ce_rst_n = 1'b0;
    #1;
    chk("rst_async_valid", m_tvalid, 0);
    tick();
    ce_rst_n = 1'b1;
    tick();
    #1;
    chk("rst_after_valid", m_tvalid, 0);
    drive(1, 1, 32'hA55, 2, 16, 1);
    #1;
    chk("rst_ctrl_disabled", m_tdata, 32'hA55);
    tick();
    wr(CTRL, 32'h21);
    drive(1, 1, 32'hB00, 2, 16, 1);
    #1;
    chk("rst_counter_zero", m_tdata, 32'd0);
    tick();
    drive(0, 0, 0, 2, 16, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
